// File: rtl/host_cmd_bridge.sv
// Host byte-stream command bridge: decodes headers into memory bursts, register accesses and device reset.
// Define HOST_CMD_BRIDGE_WR_ACK_EN to emit a 0xA5 acknowledge byte after each memory write burst.
module host_cmd_bridge #(
    parameter int unsigned ADDR_BITS = 14,
    parameter int unsigned LEN_BITS  = 14
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_in_valid,
    output logic                 o_in_ready,
    input  logic [7:0]           i_in_data,
    output logic                 o_out_valid,
    input  logic                 i_out_ready,
    output logic [7:0]           o_out_data,
    output logic                 o_mem_req,
    output logic                 o_mem_we,
    output logic [ADDR_BITS-2:0] o_mem_addr,
    output logic [7:0]           o_mem_wdata,
    input  logic [7:0]           i_mem_rdata,
    output logic                 o_dev_rst,
    output logic                 o_cpu_en,
    input  logic                 i_cpu_halted
);
    localparam int unsigned FIELD_W   = 4 + ADDR_BITS + LEN_BITS;
    localparam int unsigned HDR_BYTES = (FIELD_W + 7) / 8;
    localparam int unsigned HDR_W     = HDR_BYTES * 8;
    localparam int unsigned CNT_W     = $clog2(HDR_BYTES + 1);
    localparam int unsigned MA_W      = ADDR_BITS - 1;

    typedef enum logic [2:0] {
        S_HDR,
        S_DECODE,
        S_RST,
        S_RD_REQ,
        S_RD_DATA,
        S_WR
`ifdef HOST_CMD_BRIDGE_WR_ACK_EN
        , S_ACK
`endif
    } state_t;

    state_t              state_q, state_d;
    logic [HDR_W-1:0]    hdr_q, hdr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [MA_W-1:0]     addr_q, addr_d;
    logic [LEN_BITS-1:0] rem_q, rem_d;
    logic [7:0]          data_q, data_d;
    logic                pend_q, pend_d;
    logic                cpu_en_q, cpu_en_d;
    logic                err_q, err_d;
    logic                live_q;

    logic [3:0]           hdr_id;
    logic [ADDR_BITS-1:0] hdr_addr;
    logic [LEN_BITS-1:0]  hdr_len;
    logic                 reg_space;
    logic [MA_W-1:0]      reg_idx;
    logic                 unused_hdr;

    assign hdr_len    = hdr_q[LEN_BITS-1:0];
    assign hdr_addr   = hdr_q[LEN_BITS +: ADDR_BITS];
    assign hdr_id     = hdr_q[LEN_BITS+ADDR_BITS +: 4];
    assign reg_space  = hdr_addr[ADDR_BITS-1];
    assign reg_idx    = hdr_addr[MA_W-1:0];
    assign unused_hdr = ^hdr_q;
    assign o_cpu_en   = cpu_en_q;

    always_comb begin
        state_d     = state_q;
        hdr_d       = hdr_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        rem_d       = rem_q;
        data_d      = data_q;
        pend_d      = 1'b0;
        cpu_en_d    = cpu_en_q;
        err_d       = err_q;
        o_in_ready  = 1'b0;
        o_out_valid = 1'b0;
        o_out_data  = pend_q ? i_mem_rdata : data_q;
        o_mem_req   = 1'b0;
        o_mem_we    = 1'b0;
        o_mem_addr  = addr_q;
        o_mem_wdata = i_in_data;
        o_dev_rst   = 1'b0;

        // Halt-driven clear is the default; explicit host writes below override it.
        if (cpu_en_q && i_cpu_halted) cpu_en_d = 1'b0;

        case (state_q)
            S_HDR: begin
                o_in_ready = live_q;
                if (live_q && i_in_valid) begin
                    hdr_d[8*cnt_q +: 8] = i_in_data;
                    if (cnt_q == CNT_W'(HDR_BYTES - 1)) begin
                        cnt_d   = '0;
                        state_d = S_DECODE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_DECODE: begin
                state_d = S_HDR;
                case (hdr_id)
                    4'd0: state_d = S_RST;
                    4'd1: begin
                        if (reg_space) begin
                            if (reg_idx == MA_W'(0))      data_d = {7'b0, cpu_en_q};
                            else if (reg_idx == MA_W'(1)) data_d = {5'b0, err_q, i_cpu_halted, cpu_en_q};
                            else                          data_d = 8'h00;
                            rem_d   = '0;
                            state_d = S_RD_DATA;
                        end else begin
                            addr_d  = hdr_addr[MA_W-1:0];
                            rem_d   = hdr_len;
                            state_d = S_RD_REQ;
                        end
                    end
                    4'd2: begin
                        if (reg_space) begin
                            if (reg_idx == MA_W'(0))                   cpu_en_d = hdr_len[0];
                            else if (reg_idx == MA_W'(1) && hdr_len[2]) err_d    = 1'b0;
                        end else begin
                            addr_d  = hdr_addr[MA_W-1:0];
                            rem_d   = hdr_len;
                            state_d = S_WR;
                        end
                    end
                    default: err_d = 1'b1;
                endcase
            end
            S_RST: begin
                o_dev_rst = 1'b1;
                cpu_en_d  = 1'b0;
                state_d   = S_HDR;
            end
            S_RD_REQ: begin
                o_mem_req = 1'b1;
                pend_d    = 1'b1;
                state_d   = S_RD_DATA;
            end
            S_RD_DATA: begin
                o_out_valid = 1'b1;
                // Memory data is only valid in the first cycle here; hold a copy for stalls.
                if (pend_q) data_d = i_mem_rdata;
                if (i_out_ready) begin
                    addr_d = addr_q + 1'b1;
                    if (rem_q == '0) begin
                        state_d = S_HDR;
                    end else begin
                        rem_d   = rem_q - 1'b1;
                        state_d = S_RD_REQ;
                    end
                end
            end
            S_WR: begin
                o_in_ready = 1'b1;
                if (i_in_valid) begin
                    o_mem_req = 1'b1;
                    o_mem_we  = 1'b1;
                    addr_d    = addr_q + 1'b1;
                    if (rem_q == '0) begin
`ifdef HOST_CMD_BRIDGE_WR_ACK_EN
                        state_d = S_ACK;
`else
                        state_d = S_HDR;
`endif
                    end else begin
                        rem_d = rem_q - 1'b1;
                    end
                end
            end
`ifdef HOST_CMD_BRIDGE_WR_ACK_EN
            S_ACK: begin
                o_out_valid = 1'b1;
                o_out_data  = 8'hA5;
                if (i_out_ready) state_d = S_HDR;
            end
`endif
            default: state_d = S_HDR;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= S_HDR;
            hdr_q    <= '0;
            cnt_q    <= '0;
            addr_q   <= '0;
            rem_q    <= '0;
            data_q   <= '0;
            pend_q   <= 1'b0;
            cpu_en_q <= 1'b0;
            err_q    <= 1'b0;
            live_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            hdr_q    <= hdr_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            rem_q    <= rem_d;
            data_q   <= data_d;
            pend_q   <= pend_d;
            cpu_en_q <= cpu_en_d;
            err_q    <= err_d;
            live_q   <= 1'b1;
        end
    end
endmodule

// File: tb/tb_host_cmd_bridge.sv
// Self-checking bench for host_cmd_bridge: directed vector table, corner sequences and random commands.
module tb_host_cmd_bridge;
    localparam int TMO = 200;
`ifdef HOST_CMD_BRIDGE_WR_ACK_EN
    localparam bit ACK = 1'b1;
`else
    localparam bit ACK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_data = 8'h00;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  out_data;
    logic        mem_req, mem_we;
    logic [12:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = 8'h00;
    logic        dev_rst, cpu_en;
    logic        cpu_halted = 1'b0;

    int total = 0;
    int bad = 0;
    int dev_cnt = 0;
    logic [7:0] mem [8192];
    logic [7:0] mem_ref [8192];
    bit ref_en = 1'b0;
    bit ref_err = 1'b0;

    typedef struct {
        logic [31:0] hdr;
        int          npay;
        logic [7:0]  p0, p1;
        int          nout;
        logic [7:0]  e0, e1;
        logic        en;
        int          devp;
        int          waddr;
    } vec_t;

    always #5 clk = ~clk;

    host_cmd_bridge #(.ADDR_BITS(14), .LEN_BITS(14)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_in_valid(in_valid), .o_in_ready(in_ready), .i_in_data(in_data),
        .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_data(out_data),
        .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
        .i_mem_rdata(mem_rdata), .o_dev_rst(dev_rst), .o_cpu_en(cpu_en), .i_cpu_halted(cpu_halted)
    );

    always @(posedge clk) begin
        if (mem_req) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr];
        end
    end

    always @(negedge clk) if (dev_rst) dev_cnt++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s: timed out after %0d cycles", name, TMO);
    endtask

    function automatic logic [31:0] hdr(input int id, input int addr, input int len);
        return {id[3:0], addr[13:0], len[13:0]};
    endfunction

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        n = 0;
        while (!in_ready && n < TMO) begin
            @(negedge clk);
            n++;
        end
        if (n >= TMO) timeout("send_byte");
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // mode 0: always ready, 1: random ready, 2: ready toggles every cycle
    task automatic recv_byte(output logic [7:0] b, input int mode);
        int  n;
        bit  got;
        n = 0;
        got = 1'b0;
        b = 8'hxx;
        while (!got && n < TMO) begin
            @(negedge clk);
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = ~out_ready;
            endcase
            if (out_ready && out_valid) begin
                b = out_data;
                got = 1'b1;
                @(posedge clk);
                #1;
            end
            n++;
        end
        out_ready = 1'b0;
        if (!got) timeout("recv_byte");
    endtask

    task automatic run_cmd(input logic [31:0] h, input logic [7:0] pay[$], input int nout,
                           input int gap, input int rmode, output logic [7:0] got[$]);
        logic [7:0] b;
        got = {};
        for (int k = 0; k < 4; k++) send_byte(h[8*k +: 8], gap);
        foreach (pay[i]) send_byte(pay[i], gap);
        for (int i = 0; i < nout; i++) begin
            recv_byte(b, rmode);
            got.push_back(b);
        end
        repeat (3) @(negedge clk);
        check("no_extra_out", {31'b0, out_valid}, 32'd0);
    endtask

    // Command-level reference: what the host should observe for one command.
    task automatic model(input int id, input int addr, input int len, input logic [7:0] pay[$],
                         output logic [7:0] exp[$]);
        exp = {};
        if (id == 0) begin
            ref_en = 1'b0;
        end else if (id == 1) begin
            if (addr >= 8192) begin
                case (addr - 8192)
                    0:       exp.push_back(ref_en ? 8'd1 : 8'd0);
                    1:       exp.push_back(8'(ref_err * 4 + cpu_halted * 2 + ref_en));
                    default: exp.push_back(8'd0);
                endcase
            end else begin
                for (int i = 0; i <= len; i++) exp.push_back(mem_ref[(addr + i) % 8192]);
            end
        end else if (id == 2) begin
            if (addr >= 8192) begin
                if (addr - 8192 == 0) ref_en = (len % 2) == 1;
                else if (addr - 8192 == 1 && ((len / 4) % 2) == 1) ref_err = 1'b0;
            end else begin
                for (int i = 0; i <= len; i++) mem_ref[(addr + i) % 8192] = pay[i];
                if (ACK) exp.push_back(8'hA5);
            end
        end else begin
            ref_err = 1'b1;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       vt [13];
        logic [7:0] pay[$];
        logic [7:0] empty[$];
        logic [7:0] got[$];
        logic [7:0] exp[$];
        int         d0;
        int         nmis;

        for (int i = 0; i < 8192; i++) begin
            mem[i]     = 8'(i * 37 + 11);
            mem_ref[i] = 8'(i * 37 + 11);
        end
        empty = {};

        vt[0]  = '{32'h20040001, 2, 8'hAA, 8'hBB, 0, 8'h00, 8'h00, 1'b0, 0, 16'h10};
        vt[1]  = '{32'h10040001, 0, 8'h00, 8'h00, 2, 8'hAA, 8'hBB, 1'b0, 0, -1};
        vt[2]  = '{32'h28000001, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 1'b1, 0, -1};
        vt[3]  = '{32'h18000000, 0, 8'h00, 8'h00, 1, 8'h01, 8'h00, 1'b1, 0, -1};
        vt[4]  = '{32'hF0000000, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 1'b1, 0, -1};
        vt[5]  = '{32'h18004000, 0, 8'h00, 8'h00, 1, 8'h05, 8'h00, 1'b1, 0, -1};
        vt[6]  = '{32'h28004004, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 1'b1, 0, -1};
        vt[7]  = '{32'h18004000, 0, 8'h00, 8'h00, 1, 8'h01, 8'h00, 1'b1, 0, -1};
        vt[8]  = '{32'h18008000, 0, 8'h00, 8'h00, 1, 8'h00, 8'h00, 1'b1, 0, -1};
        vt[9]  = '{32'h00000000, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 1'b0, 1, -1};
        vt[10] = '{32'h10044000, 0, 8'h00, 8'h00, 1, 8'hBB, 8'h00, 1'b0, 0, -1};
        vt[11] = '{32'h18000000, 0, 8'h00, 8'h00, 1, 8'h00, 8'h00, 1'b0, 0, -1};
        vt[12] = '{32'h28008007, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 1'b0, 0, -1};

        // Reset state, including in_ready low until the first clock after release
        repeat (3) @(negedge clk);
        check("rst_in_ready", {31'b0, in_ready}, 32'd0);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_mem_req", {31'b0, mem_req}, 32'd0);
        check("rst_dev_rst", {31'b0, dev_rst}, 32'd0);
        check("rst_cpu_en", {31'b0, cpu_en}, 32'd0);
        @(posedge clk);
        #2 rst = 1'b0;
        #1 check("ready_before_clk", {31'b0, in_ready}, 32'd0);
        @(posedge clk);
        #1 check("ready_after_clk", {31'b0, in_ready}, 32'd1);

        foreach (vt[i]) begin
            pay = {};
            if (vt[i].npay > 0) pay.push_back(vt[i].p0);
            if (vt[i].npay > 1) pay.push_back(vt[i].p1);
            exp = {};
            if (vt[i].nout > 0) exp.push_back(vt[i].e0);
            if (vt[i].nout > 1) exp.push_back(vt[i].e1);
            if (vt[i].npay > 0 && ACK) exp.push_back(8'hA5);
            d0 = dev_cnt;
            run_cmd(vt[i].hdr, pay, exp.size(), 0, 2, got);
            foreach (exp[k]) check($sformatf("vec%0d_out%0d", i, k), {24'b0, got[k]}, {24'b0, exp[k]});
            check($sformatf("vec%0d_cpu_en", i), {31'b0, cpu_en}, {31'b0, vt[i].en});
            check($sformatf("vec%0d_devrst", i), dev_cnt - d0, vt[i].devp);
            if (vt[i].waddr >= 0) begin
                mem_ref[vt[i].waddr]     = vt[i].p0;
                mem_ref[vt[i].waddr + 1] = vt[i].p1;
                check($sformatf("vec%0d_mem0", i), {24'b0, mem[vt[i].waddr]}, {24'b0, vt[i].p0});
                check($sformatf("vec%0d_mem1", i), {24'b0, mem[vt[i].waddr + 1]}, {24'b0, vt[i].p1});
            end
        end

        // Halted CPU clears run enable one cycle later
        run_cmd(hdr(2, 14'h2000, 1), empty, 0, 0, 0, got);
        check("halt_en_set", {31'b0, cpu_en}, 32'd1);
        @(negedge clk);
        cpu_halted = 1'b1;
        #1 check("halt_en_before", {31'b0, cpu_en}, 32'd1);
        @(negedge clk);
        check("halt_en_cleared", {31'b0, cpu_en}, 32'd0);
        run_cmd(hdr(1, 14'h2001, 0), empty, 1, 0, 0, got);
        check("halt_status", {24'b0, got[0]}, 32'h02);
        cpu_halted = 1'b0;

        // Burst wrapping at the top of memory with gapped input
        pay = {8'h31, 8'h32, 8'h33, 8'h34};
        run_cmd(hdr(2, 14'h1FFE, 3), pay, ACK ? 1 : 0, 1, 0, got);
        if (ACK) check("wrap_ack", {24'b0, got[0]}, 32'hA5);
        check("wrap_1ffe", {24'b0, mem[13'h1FFE]}, 32'h31);
        check("wrap_1fff", {24'b0, mem[13'h1FFF]}, 32'h32);
        check("wrap_0000", {24'b0, mem[13'h0000]}, 32'h33);
        check("wrap_0001", {24'b0, mem[13'h0001]}, 32'h34);
        mem_ref[8190] = 8'h31; mem_ref[8191] = 8'h32; mem_ref[0] = 8'h33; mem_ref[1] = 8'h34;
        run_cmd(hdr(1, 14'h1FFE, 3), empty, 4, 0, 2, got);
        foreach (pay[k]) check($sformatf("wrap_rd%0d", k), {24'b0, got[k]}, {24'b0, pay[k]});

        // Reset in the middle of a write burst
        run_cmd(hdr(2, 14'h2000, 1), empty, 0, 0, 0, got);
        run_cmd(hdr(15, 0, 0), empty, 0, 0, 0, got);
        begin
            logic [31:0] h;
            h = hdr(2, 14'h0100, 5);
            for (int k = 0; k < 4; k++) send_byte(h[8*k +: 8], 0);
        end
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_in_ready", {31'b0, in_ready}, 32'd0);
        check("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("mid_rst_mem_req", {31'b0, mem_req}, 32'd0);
        check("mid_rst_dev_rst", {31'b0, dev_rst}, 32'd0);
        check("mid_rst_cpu_en", {31'b0, cpu_en}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1 check("mid_rel_in_ready", {31'b0, in_ready}, 32'd0);
        mem_ref[256] = 8'h11;
        mem_ref[257] = 8'h22;
        check("mid_mem_100", {24'b0, mem[256]}, 32'h11);
        check("mid_mem_101", {24'b0, mem[257]}, 32'h22);
        check("mid_mem_102", {24'b0, mem[258]}, {24'b0, mem_ref[258]});
        run_cmd(hdr(1, 14'h2001, 0), empty, 1, 0, 0, got);
        check("mid_status", {24'b0, got[0]}, 32'h00);
        ref_en = 1'b0;
        ref_err = 1'b0;

        // Random commands against the reference model
        for (int n = 0; n < 40; n++) begin
            int id, addr, len;
            case ($urandom_range(0, 5))
                0: begin id = 2; addr = $urandom_range(0, 8191); len = $urandom_range(0, 4); end
                1: begin id = 1; addr = $urandom_range(0, 8191); len = $urandom_range(0, 4); end
                2: begin id = 1; addr = 8192 + $urandom_range(0, 3); len = $urandom_range(0, 16383); end
                3: begin id = 2; addr = 8192 + $urandom_range(0, 2); len = $urandom_range(0, 7); end
                4: begin id = $urandom_range(3, 15); addr = $urandom_range(0, 16383); len = $urandom_range(0, 16383); end
                default: begin id = 0; addr = $urandom_range(0, 16383); len = $urandom_range(0, 16383); end
            endcase
            pay = {};
            if (id == 2 && addr < 8192)
                for (int i = 0; i <= len; i++) pay.push_back(8'($urandom_range(0, 255)));
            model(id, addr, len, pay, exp);
            run_cmd(hdr(id, addr, len), pay, exp.size(), $urandom_range(0, 2), 1, got);
            foreach (exp[k]) check($sformatf("rnd%0d_out%0d", n, k), {24'b0, got[k]}, {24'b0, exp[k]});
            check($sformatf("rnd%0d_cpu_en", n), {31'b0, cpu_en}, {31'b0, ref_en});
        end

        nmis = 0;
        for (int i = 0; i < 8192; i++) if (mem[i] !== mem_ref[i]) nmis++;
        check("mem_image_mismatches", nmis, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/host_cmd_bridge.md
HOST_CMD_BRIDGE -- requirements
Module: host_cmd_bridge

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 14, command address field width; MSB selects register space, low ADDR_BITS-1 bits address memory.
REQ-002 SHALL have parameter LEN_BITS, default 14, command length field width; field holds byte count minus 1.
REQ-003 SHALL derive HDR_BYTES = ceil((4+ADDR_BITS+LEN_BITS)/8) (4 at defaults); header packed {id[3:0], addr, len}, LSB-aligned, zero-extended.
REQ-004 i_clk  input  1  sole clock; all state on rising edge.
REQ-005 i_rst  input  1  asynchronous, active-high reset.
REQ-006 i_in_valid / o_in_ready / i_in_data  in/out/in  1/1/8  host byte stream; transfer when valid&ready.
REQ-007 o_out_valid / i_out_ready / o_out_data  out/in/out  1/1/8  response byte stream; transfer when valid&ready.
REQ-008 o_mem_req / o_mem_we / o_mem_addr / o_mem_wdata  out  1/1/ADDR_BITS-1/8  byte memory port, one access per req cycle.
REQ-009 i_mem_rdata  input  8  read data, valid exactly one cycle after a req with we=0.
REQ-010 o_dev_rst  output  1  one-cycle device reset pulse.
REQ-011 o_cpu_en  output  1  CPU run enable; i_cpu_halted  input  1  CPU halted flag.

Function
REQ-012 States: HDR, DECODE, RST, RD_REQ, RD_DATA, WR, ACK; all commands start in HDR.
REQ-013 HDR: o_in_ready=1; byte k (0..HDR_BYTES-1) loads header bits [8k+7:8k] (little-endian); after last byte -> DECODE.
REQ-014 DECODE, id 0: o_dev_rst=1 for one cycle in RST, clears o_cpu_en, -> HDR.
REQ-015 id 1, memory: RD_REQ issues req we=0 at current addr -> RD_DATA; RD_DATA holds o_out_valid with captured i_mem_rdata until accepted; addr+1; remaining>0 -> RD_REQ else HDR.
REQ-016 id 2, memory: WR holds o_in_ready=1; each accepted byte issues req we=1 same cycle with that byte; addr+1; after len+1 bytes -> ACK/HDR per REQ-025.
REQ-017 Empty input in WR or full output in RD_* SHALL stall, never abort; no byte lost, duplicated or reordered.
REQ-018 Memory address arithmetic SHALL wrap modulo 2^(ADDR_BITS-1); a burst crossing the top continues at 0.
REQ-019 id 1, register space: emits exactly one byte (len ignored): reg 0 = {7'b0,o_cpu_en}; reg 1 = {5'b0,err,i_cpu_halted,o_cpu_en}; other regs 0x00.
REQ-020 id 2, register space: reg 0 sets o_cpu_en = len[0]; reg 1 write of len[2]=1 clears err; others ignored; no data bytes consumed.
REQ-021 While o_cpu_en=1 and i_cpu_halted=1, o_cpu_en SHALL clear next cycle; a same-cycle host write to reg 0 wins.
REQ-022 id 3..15: set sticky err, consume no payload, -> HDR.
REQ-023 o_in_ready SHALL be 0 in all states except HDR and WR; o_mem_req SHALL be 0 outside RD_REQ and WR.

Reset
REQ-024 On i_rst: state HDR, header/byte counter 0, o_cpu_en=0, err=0, o_dev_rst=0, o_out_valid=0, o_mem_req=0, o_in_ready=0 until first clock after release; in-flight burst discarded, no partial response after release.

Configuration
REQ-025 Macro HOST_CMD_BRIDGE_WR_ACK_EN: defined -> after memory write burst, ACK emits 0xA5 (stalls on ready) then HDR; undefined -> WR -> HDR directly, ACK state absent.

Verification
REQ-026 Bytes 01 00 04 20, AA, BB -> mem[0x10]=AA, mem[0x11]=BB; with WR_ACK_EN one out byte A5.
REQ-027 Then bytes 01 00 04 10 with i_out_ready toggled every other cycle -> out AA then BB, no duplicates.
REQ-028 Bytes 01 00 00 28 -> o_cpu_en=1; assert i_cpu_halted -> o_cpu_en=0 next cycle; bytes 00 40 00 18 -> out 0x02.
REQ-029 Bytes 00 00 00 F0 -> status read returns bit2=1; write 04 40 00 28 -> subsequent status bit2=0.
REQ-030 Write len=3 at addr 0x1FFE with 1-cycle input gaps -> bytes at 1FFE,1FFF,0000,0001; i_rst mid-burst -> all outputs reset values, next header decoded cleanly.
